// File: rtl/system_key_pio_in.sv
// system_key_pio_in: Avalon-MM input PIO with two-flop synchroniser,
// per-bit debounce, selectable edge capture (W1C) and a masked level irq.
// Build option: define KEY_PIO_DEBOUNCE_EN to include the debounce counters;
// without it the debounced value is simply the synchroniser output registered.
// Register map: 0 DATA (RO), 1 RAW (RO), 2 MASK (RW), 3 EDGE (R/W1C).
module system_key_pio_in #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter bit          IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      rd_next;
    logic             rd_en;
    logic             wr_en;
    logic             unused_bits;

    assign rd_en = chipselect & ~read_n;
    assign wr_en = chipselect & ~write_n;

    // Upper write-data bits and the debounce length (in the bypass build)
    // have no function here.
    assign unused_bits = &{1'b0, writedata, DEBOUNCE_CYCLES[0]};

    // Two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IDLE_VEC;
            sync2 <= IDLE_VEC;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt [WIDTH];

    // Per-bit debounce: accept a new level only after it has differed from
    // the accepted level for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= IDLE_VEC;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    // Debounce bypassed: accepted level follows the synchroniser one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= IDLE_VEC;
        end else begin
            stable <= sync2;
        end
    end
`endif

    // Edge vector of the accepted level, selected by EDGE_TYPE
    always_comb begin
        edge_vec = '0;
        case (EDGE_TYPE)
            0:       edge_vec = stable & ~stable_d;
            1:       edge_vec = ~stable & stable_d;
            default: edge_vec = stable ^ stable_d;
        endcase
    end

    assign edge_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Delayed level, irq mask and edge capture; a new edge overrides a W1C clear
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= IDLE_VEC;
            mask     <= '0;
            edge_cap <= '0;
        end else begin
            stable_d <= stable;
            if (wr_en && address == 2'd2) begin
                mask <= writedata[WIDTH-1:0];
            end
            edge_cap <= (edge_cap & ~edge_clr) | edge_vec;
        end
    end

    // Zero-extended read mux
    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = stable;
            2'd1:    rd_next[WIDTH-1:0] = sync2;
            2'd2:    rd_next[WIDTH-1:0] = mask;
            default: rd_next[WIDTH-1:0] = edge_cap;
        endcase
    end

    // Registered read data (read latency 1), held when not strobed
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_next;
        end
    end

    assign irq = |(edge_cap & mask);

endmodule

// File: tb/tb_system_key_pio_in.sv
// Testbench for system_key_pio_in: directed test-plan sequence followed by
// randomized bus/pin traffic, all checked against a behavioural model.
module tb_system_key_pio_in;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DC    = 4;
`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int unsigned WIN         = DC;
    localparam logic [31:0] GLITCH_EDGE = 32'h0;
`else
    localparam int unsigned WIN         = 1;
    localparam logic [31:0] GLITCH_EDGE = 32'h1;
`endif
    // pin change to DATA latency
    localparam int unsigned LAT = 2 + WIN;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             read_n;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        chk_en = 1'b0;

    system_key_pio_in #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DC),
        .EDGE_TYPE(1),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .read_n(read_n),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pins pass a 2-cycle delay line; the accepted level of a bit flips once
    // the last WIN delayed samples all disagree with it.
    logic [3:0]  m_sync1, m_sync2, m_stable, m_prev, m_mask, m_edge;
    logic [31:0] m_rd;
    logic [3:0]  hist[$];

    always @(posedge clk) begin
        logic [3:0]  fell;
        logic [3:0]  nxt;
        int unsigned run;
        if (reset) begin
            m_sync1 = 4'hF; m_sync2 = 4'hF; m_stable = 4'hF; m_prev = 4'hF;
            m_mask = 4'h0; m_edge = 4'h0; m_rd = 32'h0;
            hist.delete();
        end else begin
            if (chipselect && !read_n) begin
                case (address)
                    2'd0: m_rd = {28'h0, m_stable};
                    2'd1: m_rd = {28'h0, m_sync2};
                    2'd2: m_rd = {28'h0, m_mask};
                    default: m_rd = {28'h0, m_edge};
                endcase
            end
            fell = m_prev & ~m_stable;   // was high last cycle, low now
            if (chipselect && !write_n && address == 2'd3)
                m_edge = (m_edge & ~writedata[3:0]) | fell;
            else
                m_edge = m_edge | fell;
            if (chipselect && !write_n && address == 2'd2)
                m_mask = writedata[3:0];
            hist.push_back(m_sync2);
            if (hist.size() > WIN) hist.delete(0);
            nxt = m_stable;
            for (int b = 0; b < 4; b++) begin
                run = 0;
                foreach (hist[k]) if (hist[k][b] != m_stable[b]) run++;
                if (hist.size() == WIN && run == WIN) nxt[b] = ~m_stable[b];
            end
            m_prev   = m_stable;
            m_stable = nxt;
            m_sync2  = m_sync1;
            m_sync1  = in_port;
        end
    end

    // Continuous comparison of every observable output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rd", readdata, m_rd);
            check("model_irq", {31'h0, irq}, {31'h0, |(m_edge & m_mask)});
        end
    end

    // ---------------- bus helpers ----------------
    task automatic idle_bus();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = a;
        @(negedge clk);
        idle_bus();
        v = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
        @(negedge clk);
        idle_bus();
    endtask

    initial begin
        logic [31:0] v;
        logic        seen;
        logic        found;
        logic        prev_irq;
        int unsigned n;

        // 1: reset with pins idle
        reset = 1'b1; in_port = 4'hF; address = 2'd0; writedata = 32'h0;
        idle_bus();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_irq", {31'h0, irq}, 32'h0);
        rd(2'd0, v); check("rst_data", v, 32'hF);
        rd(2'd2, v); check("rst_mask", v, 32'h0);
        rd(2'd3, v); check("rst_edge", v, 32'h0);
        check("rst_irq2", {31'h0, irq}, 32'h0);

        // 2: 3-cycle low pulse on pin 0
        in_port = 4'hE;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) in_port = 4'hF;
            chipselect = 1'b1; read_n = 1'b0; address = 2'd1;
            @(negedge clk);
            if (readdata[3:0] == 4'hE) seen = 1'b1;
        end
        idle_bus();
        check("raw_pulse", {31'h0, seen}, 32'h1);
        repeat (8) @(negedge clk);
        rd(2'd0, v); check("glitch_data", v, 32'hF);
        rd(2'd3, v); check("glitch_edge", v, GLITCH_EDGE);
        wr(2'd3, 32'hF);

        // 3: mask bit 0, hold pin 0 low, poll DATA every cycle
        wr(2'd2, 32'h1);
        in_port = 4'hE;
        n = 0; found = 1'b0; prev_irq = irq;
        while (!found && n < 40) begin
            chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
            @(negedge clk);
            n++;
            if (readdata[3:0] == 4'hE) begin
                found = 1'b1;
                check("irq_at_data", {31'h0, irq}, 32'h1);
                check("irq_before", {31'h0, prev_irq}, 32'h0);
            end else begin
                prev_irq = irq;
            end
        end
        idle_bus();
        check("data_latency", n, LAT + 1);
        rd(2'd3, v); check("edge_set", v, 32'h1);
        check("irq_set", {31'h0, irq}, 32'h1);

        // 4: W1C clear of bit 0
        wr(2'd3, 32'h1);
        check("irq_clr", {31'h0, irq}, 32'h0);
        rd(2'd3, v); check("edge_clr", v, 32'h0);
        rd(2'd0, v); check("data_after_clr", v, 32'hE);

        // 5: edge on bit 1 lands together with a W1C of bit 1
        in_port = 4'hC;
        repeat (LAT) @(negedge clk);
        wr(2'd3, 32'h2);
        check("irq_unmasked", {31'h0, irq}, 32'h0);
        rd(2'd3, v); check("set_wins", v, 32'h2);
        wr(2'd3, 32'h2);
        rd(2'd3, v); check("edge_clr2", v, 32'h0);

        // 6: reset in the middle of a debounce on pin 2
        in_port = 4'h8;
        repeat (4) @(negedge clk);
        reset = 1'b1; in_port = 4'hF;
        @(negedge clk);
        reset = 1'b0;
        rd(2'd0, v); check("rst2_data", v, 32'hF);
        rd(2'd1, v); check("rst2_raw", v, 32'hF);
        rd(2'd2, v); check("rst2_mask", v, 32'h0);
        rd(2'd3, v); check("rst2_edge", v, 32'h0);
        check("rst2_irq", {31'h0, irq}, 32'h0);
        repeat (10) @(negedge clk);
        rd(2'd3, v); check("rst2_edge_late", v, 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            int unsigned op;
            if ($urandom_range(0, 5) == 0)
                in_port = in_port ^ (4'h1 << $urandom_range(0, 3));
            op = $urandom_range(0, 3);
            chipselect = (op != 0) || ($urandom_range(0, 1) == 1);
            read_n     = !(op == 1 || op == 3);
            write_n    = !(op == 2 || op == 3);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            reset      = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        idle_bus();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/system_key_pio_in.md
# system_key_pio_in

Avalon-MM slave input port: the read-side counterpart of the seven-segment output PIO. It samples external pins (pushbuttons/switches), synchronises and debounces them, latches selected edges into a capture register, and raises a level interrupt to the Nios II. It sits on the system interconnect beside the output PIOs and feeds `readdata` back to the CPU.

## Interface

Parameters:
- `WIDTH`, 4, number of input pins (1..32).
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required before a change is accepted (≥1).
- `EDGE_TYPE`, 1, edge to capture: 0 rising, 1 falling, 2 any.
- `IDLE_LEVEL`, 1, reset value of the synchroniser and debounced registers (each bit).

Ports:
- `clk`  in  1  single clock domain. Everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `read_n`  in  1  active-low read strobe.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  asynchronous external pins.
- `readdata`  out  32  registered read data, upper bits zero.
- `irq`  out  1  level interrupt.

## Operation

- Register map (word address):
  - 0 DATA, RO: debounced value.
  - 1 RAW, RO: synchroniser output.
  - 2 MASK, RW: `WIDTH` bits, irq enable.
  - 3 EDGE, R/W1C: edge capture.
- Writes to 0 and 1 are ignored.
- Synchroniser: two flops per bit (`sync1`, then `sync2`).
- Debounce, per bit, using counter `cnt[i]` of width clog2(`DEBOUNCE_CYCLES`+1):
  - `sync2[i] == stable[i]`: `cnt[i]` clears to 0.
  - `sync2[i] != stable[i]`: `cnt[i]` increments.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 while the bits still differ, `stable[i]` takes `sync2[i]` and `cnt[i]` clears in the same cycle.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `stable`.
- Edge detect: `stable_d` is `stable` delayed one cycle. The edge vector is:
  - rising: `stable & ~stable_d`
  - falling: `~stable & stable_d`
  - any: XOR of the two.
- Edge capture: each detected edge sets `edge_cap[i]`. A write to address 3 clears every bit `i` where `writedata[i]` is 1. If set and clear hit the same bit in the same cycle, set wins.
- `irq` = OR-reduce(`edge_cap` & `mask`), driven combinationally from registers.
- Read: when `chipselect` is high and `read_n` is low, `readdata` loads the selected register, zero-extended. Otherwise `readdata` holds its value. Reading does not clear EDGE.
- Reset values:
  - `sync1`, `sync2`, `stable`, `stable_d` = {`WIDTH`{`IDLE_LEVEL`}}.
  - `cnt`, `mask`, `edge_cap`, `readdata` = 0.
  - Therefore `irq` = 0.
- Reset asserted mid-debounce or mid-capture discards all progress. No edge is reported on reset release when the pins are at `IDLE_LEVEL`.

## Timing

- Pin change to RAW visible: 2 cycles.
- Pin change to DATA (`stable`) update: 2 + `DEBOUNCE_CYCLES` cycles.
- `stable` change to `edge_cap` set: 1 cycle. `irq` asserts in the same cycle as `edge_cap` when masked in.
- Read latency: 1. `readdata` is valid on the cycle after the strobe, which gives Avalon readLatency = 1.
- Write takes effect at the strobe edge. `irq` drops in the cycle after a W1C write, unless a new edge sets the bit that same cycle.
- Back-to-back reads and writes are supported every cycle. There is no waitrequest.

## Configuration

- Macro: `KEY_PIO_DEBOUNCE_EN`.
- Defined: debounce counters are present, as described above.
- Undefined: no counters are built; `stable` = `sync2` registered (one extra cycle); `DEBOUNCE_CYCLES` is ignored.
  - Pin to DATA latency becomes 3 cycles.
  - Any 1-cycle-wide change that survives the synchroniser is captured.

## Test plan

Bench settings: `WIDTH`=4, `DEBOUNCE_CYCLES`=4, `EDGE_TYPE`=1, `IDLE_LEVEL`=1, debounce enabled.

1. Reset with `in_port`=4'hF, then read addresses 0, 2 and 3. Expect readdata 32'hF, 0 and 0 on the following cycles, and `irq`=0 throughout.
2. Drive `in_port`[0] low for 3 cycles, then high.
   - RAW shows the pulse.
   - DATA stays 4'hF.
   - EDGE stays 0.
3. Write MASK=4'h1, then hold `in_port`[0] low.
   - DATA becomes 4'hE exactly 6 cycles after the pin change.
   - EDGE=4'h1 one cycle later.
   - `irq`=1.
4. Write 32'h1 to address 3. Expect EDGE=0 and `irq`=0 on the next cycle. A read of DATA still returns 4'hE.
5. Drop `in_port`[1] so that its debounced edge lands in the same cycle as a W1C write of 32'h2. Expect EDGE[1]=1 (set wins). With MASK=4'h1, expect `irq` to stay 0.
6. Assert `reset` for 1 cycle while `cnt[2]`=2 (mid-debounce). Expect all registers back at their reset values and no edge captured on release.
